// File: rtl/png_pkg.sv
// Shared definitions for the PNG encoder chunk path.
//   - Chunk type words (IHDR / IDAT / IEND) as emitted ahead of chunk data.
//   - Default packed word width and byte-count code width used by crc32_top.
//   - State encoding of the chunk packer.
package png_pkg;

  localparam int unsigned PNG_DATA_WD = 32;
  localparam int unsigned PNG_NUM_WD  = 2;

  localparam logic [31:0] CHUNK_IHDR = 32'h49484452;
  localparam logic [31:0] CHUNK_IDAT = 32'h49444154;
  localparam logic [31:0] CHUNK_IEND = 32'h49454E44;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StDone = 2'd2
  } pack_state_e;

endpackage

// File: rtl/crc32_pack.sv
// crc32_pack: feeds crc32_top with one PNG chunk (type word + data bytes).
//
// Data bytes arrive one per cycle; they are preceded by the chunk type word
// TYPE_VAL and packed big-endian (first byte in [31:24]) into DATA_WD-bit
// words tagged with a byte-count code (valid bytes - 1) and a last flag.
//
// Ports:
//   clk      clock
//   rstn     asynchronous active-low reset
//   start_i  one-cycle chunk start pulse (taken in IDLE only)
//   val_i    data byte valid
//   dat_i    data byte
//   lst_i    last data byte (with val_i); with start_i marks an empty chunk
//   rdy_o    byte accepted when val_i && rdy_o
//   val_o    packed word valid, one-cycle pulse per word
//   dat_o    packed word, unused low bytes zero
//   num_o    valid bytes in dat_o minus 1
//   lst_o    last word of the chunk
//   done_o   one-cycle pulse after the last word
//   len_o    data-byte count of the chunk (only with CRC32_PACK_LEN_EN)
//
// Optional feature: define CRC32_PACK_LEN_EN to add the saturating data-byte
// counter and its len_o port. Without it neither the port nor the counter
// exists.
//
// All outputs are registered.
module crc32_pack
  import png_pkg::*;
#(
  parameter int unsigned        DATA_WD  = PNG_DATA_WD,
  parameter int unsigned        NUM_WD   = PNG_NUM_WD,
  parameter logic [DATA_WD-1:0] TYPE_VAL = CHUNK_IDAT,
  parameter int unsigned        LEN_WD   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [7:0]         dat_i,
  input  logic               lst_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUM_WD-1:0]  num_o,
  output logic               lst_o,
  output logic               done_o
`ifdef CRC32_PACK_LEN_EN
  ,
  output logic [LEN_WD-1:0]  len_o
`endif
);

  localparam int unsigned       NBYTES    = DATA_WD / 8;
  localparam logic [NUM_WD-1:0] LAST_SLOT = NUM_WD'(NBYTES - 1);

  pack_state_e state_q, state_d;

  // Partial word; slots not yet written are kept zero so a short final word
  // needs no extra masking.
  logic [DATA_WD-1:0] buf_q, buf_d;
  logic [NUM_WD-1:0]  cnt_q, cnt_d;

  logic               rdy_q, rdy_d;
  logic               val_q, val_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic [NUM_WD-1:0]  num_q, num_d;
  logic               lst_q, lst_d;
  logic               done_q, done_d;

  logic               accept;
  logic [DATA_WD-1:0] word;

  // rdy_q is high exactly while in DATA, so it doubles as the DATA qualifier.
  assign accept = rdy_q && val_i;

  // Buffer with the incoming byte merged into slot cnt_q.
  always_comb begin
    word = buf_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (cnt_q == NUM_WD'(i)) begin
        word[DATA_WD-1-8*i -: 8] = dat_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    val_d   = 1'b0;
    dat_d   = dat_q;
    num_d   = num_q;
    lst_d   = lst_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          val_d   = 1'b1;
          dat_d   = TYPE_VAL;
          num_d   = LAST_SLOT;
          lst_d   = lst_i;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = lst_i ? StDone : StData;
        end
      end

      StData: begin
        if (accept) begin
          if (lst_i || (cnt_q == LAST_SLOT)) begin
            val_d = 1'b1;
            dat_d = word;
            num_d = cnt_q;
            lst_d = lst_i;
            buf_d = '0;
            cnt_d = '0;
            if (lst_i) begin
              state_d = StDone;
            end
          end else begin
            buf_d = word;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        // Last word is on the outputs this cycle; done follows it.
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    rdy_d = (state_d == StData);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
      dat_q   <= '0;
      num_q   <= '0;
      lst_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      dat_q   <= dat_d;
      num_q   <= num_d;
      lst_q   <= lst_d;
      done_q  <= done_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign val_o  = val_q;
  assign dat_o  = dat_q;
  assign num_o  = num_q;
  assign lst_o  = lst_q;
  assign done_o = done_q;

`ifdef CRC32_PACK_LEN_EN
  logic [LEN_WD-1:0] len_q, len_d;

  // Counts accepted data bytes only; holds after the chunk until next start.
  always_comb begin
    len_d = len_q;
    if ((state_q == StIdle) && start_i) begin
      len_d = '0;
    end else if (accept && (len_q != {LEN_WD{1'b1}})) begin
      len_d = len_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign len_o = len_q;
`endif

endmodule

// File: tb/tb_crc32_pack.sv
// Directed bench for crc32_pack. Main instance uses the IDAT type word; a
// second instance with the IEND type word is used for the empty-chunk case.
module tb_crc32_pack;
  import png_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic        val_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        lst_i = 1'b0;

  logic        rdy_o, val_o, lst_o, done_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;
  logic        e_rdy_o, e_val_o, e_lst_o, e_done_o;
  logic [31:0] e_dat_o;
  logic [1:0]  e_num_o;
`ifdef CRC32_PACK_LEN_EN
  logic [31:0] len_o, e_len_o;
`endif

  crc32_pack u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .lst_i   (lst_i),
    .rdy_o   (rdy_o),
    .val_o   (val_o),
    .dat_o   (dat_o),
    .num_o   (num_o),
    .lst_o   (lst_o),
    .done_o  (done_o)
`ifdef CRC32_PACK_LEN_EN
    ,
    .len_o   (len_o)
`endif
  );

  crc32_pack #(
    .TYPE_VAL (32'h49454E44)
  ) u_dut_end (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .lst_i   (lst_i),
    .rdy_o   (e_rdy_o),
    .val_o   (e_val_o),
    .dat_o   (e_dat_o),
    .num_o   (e_num_o),
    .lst_o   (e_lst_o),
    .done_o  (e_done_o)
`ifdef CRC32_PACK_LEN_EN
    ,
    .len_o   (e_len_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  n;
    logic        l;
    int          c;
  } word_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  word_t words[$];
  int    done_cyc[$];
  int    e_rdy_seen = 0;

  // Capture every word and done pulse of the main instance mid-cycle.
  always @(negedge clk) begin
    word_t w;
    cyc = cyc + 1;
    if (val_o) begin
      w.d = dat_o;
      w.n = num_o;
      w.l = lst_o;
      w.c = cyc;
      words.push_back(w);
    end
    if (done_o) done_cyc.push_back(cyc);
    if (e_rdy_o) e_rdy_seen = e_rdy_seen + 1;
  end

  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l);
    start_i = s;
    val_i   = v;
    dat_i   = d;
    lst_i   = l;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    val_i   = 1'b0;
    dat_i   = 8'h00;
    lst_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    words.delete();
    done_cyc.delete();
  endtask

  task automatic test_reset();
    idle(2);
    n_vec++;
    if ({rdy_o, val_o, dat_o, num_o, lst_o, done_o} !== 37'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {rdy_o, val_o, dat_o, num_o, lst_o, done_o});
    end
`ifdef CRC32_PACK_LEN_EN
    n_vec++;
    if (len_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_len: got %0d want 0", len_o);
    end
`endif
    rdy_o_dummy_release();
  endtask

  task automatic rdy_o_dummy_release();
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_five_bytes();
    logic [31:0] exp_d[3] = '{32'h49444154, 32'h01020304, 32'h05000000};
    logic [1:0]  exp_n[3] = '{2'd3, 2'd3, 2'd0};
    logic        exp_l[3] = '{1'b0, 1'b0, 1'b1};
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i), i == 5);
    idle(4);
    n_vec++;
    if (words.size() !== 3) begin
      n_err++;
      $display("FAIL five_count: got %0d words want 3", words.size());
    end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      n_vec++;
      if (words[i].d !== exp_d[i] || words[i].n !== exp_n[i] || words[i].l !== exp_l[i]) begin
        n_err++;
        $display("FAIL five_word%0d: got %h/%0d/%0d want %h/%0d/%0d", i, words[i].d,
                 words[i].n, words[i].l, exp_d[i], exp_n[i], exp_l[i]);
      end
    end
    if (words.size() == 3) begin
      n_vec++;
      if (words[1].c - words[0].c !== 4 || words[2].c - words[1].c !== 1) begin
        n_err++;
        $display("FAIL five_timing: got gaps %0d,%0d want 4,1", words[1].c - words[0].c,
                 words[2].c - words[1].c);
      end
      n_vec++;
      if (done_cyc.size() !== 1 || (done_cyc.size() == 1 && done_cyc[0] !== words[2].c + 1)) begin
        n_err++;
        $display("FAIL five_done: got %0d pulses want 1 pulse one cycle after last word",
                 done_cyc.size());
      end
    end
`ifdef CRC32_PACK_LEN_EN
    n_vec++;
    if (len_o !== 32'd5) begin
      n_err++;
      $display("FAIL five_len: got %0d want 5", len_o);
    end
`endif
  endtask

  task automatic test_empty_chunk();
    e_rdy_seen = 0;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    n_vec++;
    if ({e_val_o, e_dat_o, e_num_o, e_lst_o, e_done_o} !== {1'b1, 32'h49454E44, 2'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL empty_word: got %b/%h/%0d/%b/%b want 1/49454e44/3/1/0", e_val_o, e_dat_o,
               e_num_o, e_lst_o, e_done_o);
    end
    idle(1);
    n_vec++;
    if ({e_val_o, e_done_o} !== 2'b01) begin
      n_err++;
      $display("FAIL empty_done: got val=%b done=%b want val=0 done=1", e_val_o, e_done_o);
    end
    idle(2);
    n_vec++;
    if (e_rdy_seen !== 0 || e_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL empty_rdy: got rdy cycles=%0d done=%b want 0/0", e_rdy_seen, e_done_o);
    end
`ifdef CRC32_PACK_LEN_EN
    n_vec++;
    if (e_len_o !== 32'd0) begin
      n_err++;
      $display("FAIL empty_len: got %0d want 0", e_len_o);
    end
`endif
  endtask

  task automatic test_eight_bytes();
    logic [31:0] exp_d[3] = '{32'h49444154, 32'h11121314, 32'h15161718};
    logic        exp_l[3] = '{1'b0, 1'b0, 1'b1};
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h11 + 8'(i), i == 7);
    idle(4);
    n_vec++;
    if (words.size() !== 3 || done_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL eight_count: got %0d words %0d done want 3/1", words.size(), done_cyc.size());
    end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      n_vec++;
      if (words[i].d !== exp_d[i] || words[i].n !== 2'd3 || words[i].l !== exp_l[i]) begin
        n_err++;
        $display("FAIL eight_word%0d: got %h/%0d/%0d want %h/3/%0d", i, words[i].d, words[i].n,
                 words[i].l, exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] b[3] = '{8'hAA, 8'hBB, 8'hCC};
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, b[i], i == 2);
      if (i < 2) idle(2);
    end
    idle(4);
    n_vec++;
    if (words.size() !== 2) begin
      n_err++;
      $display("FAIL gap_count: got %0d words want 2", words.size());
    end
    if (words.size() >= 2) begin
      n_vec++;
      if (words[1].d !== 32'hAABBCC00 || words[1].n !== 2'd2 || words[1].l !== 1'b1) begin
        n_err++;
        $display("FAIL gap_word: got %h/%0d/%0d want aabbcc00/2/1", words[1].d, words[1].n,
                 words[1].l);
      end
    end
  endtask

  task automatic test_reset_mid_chunk();
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hB1, 1'b0);
    step(1'b0, 1'b1, 8'hB2, 1'b0);
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({rdy_o, val_o, dat_o, num_o, lst_o, done_o} !== 37'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h want 0", {rdy_o, val_o, dat_o, num_o, lst_o, done_o});
    end
    idle(2);
    rstn = 1'b1;
    idle(2);
    n_vec++;
    if (words.size() !== 1 || done_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL midreset_quiet: got %0d words %0d done want 1/0", words.size(),
               done_cyc.size());
    end
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hC1 + 8'(i), i == 3);
    idle(4);
    n_vec++;
    if (words.size() !== 2) begin
      n_err++;
      $display("FAIL midreset_count: got %0d words want 2", words.size());
    end
    if (words.size() >= 2) begin
      n_vec++;
      if (words[1].d !== 32'hC1C2C3C4 || words[1].n !== 2'd3 || words[1].l !== 1'b1) begin
        n_err++;
        $display("FAIL midreset_word: got %h/%0d/%0d want c1c2c3c4/3/1", words[1].d, words[1].n,
                 words[1].l);
      end
    end
  endtask

  task automatic test_start_in_data();
    clear_log();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h23, 1'b1);
    idle(4);
    n_vec++;
    if (words.size() !== 2) begin
      n_err++;
      $display("FAIL stray_count: got %0d words want 2", words.size());
    end
    if (words.size() >= 2) begin
      n_vec++;
      if (words[1].d !== 32'h21222300 || words[1].n !== 2'd2 || words[1].l !== 1'b1) begin
        n_err++;
        $display("FAIL stray_word: got %h/%0d/%0d want 21222300/2/1", words[1].d, words[1].n,
                 words[1].l);
      end
    end
`ifdef CRC32_PACK_LEN_EN
    n_vec++;
    if (len_o !== 32'd3) begin
      n_err++;
      $display("FAIL stray_len: got %0d want 3", len_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_five_bytes();
    test_empty_chunk();
    test_eight_bytes();
    test_gapped();
    test_reset_mid_chunk();
    test_start_in_data();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
